// File: rtl/fc_data_mover_ncore_pkg.sv
// fc_pkg: state encodings and width helpers shared by the FC data mover slice.
package fc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Accumulator width per lane: generous headroom over the 2*w product.
    function automatic int fc_acc_w(input int in_w);
        return 4 * in_w;
    endfunction

endpackage

// File: rtl/fc_data_mover_ncore_if.sv
// BRAM-side bus of the FC data mover: node read port (b0), weight read
// port (b1) and result write port (b2).
interface fc_data_mover_ncore_if
    import fc_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int OWIDTH = (DWIDTH / 8) * fc_acc_w(8)
);
    logic [AWIDTH-1:0] addr_b0;
    logic              ce_b0;
    logic              we_b0;
    logic [DWIDTH-1:0] d_b0;
    logic [DWIDTH-1:0] q_b0;

    logic [AWIDTH-1:0] addr_b1;
    logic              ce_b1;
    logic              we_b1;
    logic [DWIDTH-1:0] d_b1;
    logic [DWIDTH-1:0] q_b1;

    logic [AWIDTH-1:0] addr_b2;
    logic              ce_b2;
    logic              we_b2;
    logic [OWIDTH-1:0] d_b2;

    modport master (
        output addr_b0, ce_b0, we_b0, d_b0, input q_b0,
        output addr_b1, ce_b1, we_b1, d_b1, input q_b1,
        output addr_b2, ce_b2, we_b2, d_b2
    );

    modport slave (
        input addr_b0, ce_b0, we_b0, d_b0, output q_b0,
        input addr_b1, ce_b1, we_b1, d_b1, output q_b1,
        input addr_b2, ce_b2, we_b2, d_b2
    );
endinterface

// File: rtl/fc_data_mover_ncore_mac_lane.sv
// fc_mac_lane: one signed multiply-accumulate lane. The accumulator loads
// the product on the first element of a node and adds afterwards, wrapping
// in two's complement. ReLU is applied on the output view only.
module fc_mac_lane #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_vld,
    input  logic                    i_first,
    input  logic                    i_relu,
    input  logic signed [IN_W-1:0]  i_a,
    input  logic signed [IN_W-1:0]  i_b,
    output logic [ACC_W-1:0]        o_res
);
    logic signed [2*IN_W-1:0] w_a_ext;
    logic signed [2*IN_W-1:0] w_b_ext;
    logic signed [2*IN_W-1:0] w_prod;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [ACC_W-1:0]         r_acc;

    assign w_a_ext    = {{IN_W{i_a[IN_W-1]}}, i_a};
    assign w_b_ext    = {{IN_W{i_b[IN_W-1]}}, i_b};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(ACC_W-2*IN_W){w_prod[2*IN_W-1]}}, w_prod};

    // accumulate aligned operand pairs; first element of a node restarts the sum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_acc <= '0;
        else if (i_vld)
            r_acc <= i_first ? w_prod_ext : r_acc + w_prod_ext;
    end

    assign o_res = (i_relu && r_acc[ACC_W-1]) ? '0 : r_acc;

endmodule

// File: rtl/fc_data_mover_ncore.sv
// fc_data_mover_ncore: streams N node words and N*M weight words from two
// BRAMs, one read per cycle, and writes one multi-lane dot product per
// output node into the result BRAM two cycles after its last read.
module fc_data_mover_ncore
    import fc_pkg::*;
#(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 12,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    input  logic [CNT_BIT-1:0] i_num_out,
    input  logic               i_relu_en,
    output logic               o_idle,
    output logic               o_run,
    output logic               o_done,
    fc_data_mover_ncore_if.master bus
);
    localparam int NUM_LANE = DWIDTH / IN_DATA_WIDTH;
    localparam int ACC_W    = fc_acc_w(IN_DATA_WIDTH);
    localparam logic [CNT_BIT-1:0] C_ONE = CNT_BIT'(1);
    localparam logic [AWIDTH-1:0]  A_ONE = AWIDTH'(1);

    logic [1:0]                r_state;
    logic [CNT_BIT-1:0]        r_num_cnt;
    logic [CNT_BIT-1:0]        r_num_out;
    logic [CNT_BIT-1:0]        r_in_idx;
    logic [CNT_BIT-1:0]        r_out_idx;
    logic [AWIDTH-1:0]         r_wptr;
    logic                      r_relu;

    // read-data alignment stage (q_b0/q_b1 valid while these are)
    logic                      r_vld;
    logic                      r_first;
    logic                      r_last;
    logic                      r_last_node;
    logic [AWIDTH-1:0]         r_out_d1;

    // write stage
    logic                      r_we_b2;
    logic                      r_wr_last;
    logic [AWIDTH-1:0]         r_addr_b2;

    logic                      w_issue;
    logic                      w_in_last;
    logic                      w_out_last;
    logic [NUM_LANE*ACC_W-1:0] w_d_b2;

    assign w_issue    = (r_state == ST_RUN);
    assign w_in_last  = (r_in_idx == r_num_cnt - C_ONE);
    assign w_out_last = (r_out_idx == r_num_out - C_ONE);

    // control FSM plus node/output/weight read counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_num_cnt <= '0;
            r_num_out <= '0;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_wptr    <= '0;
            r_relu    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        r_num_cnt <= i_num_cnt;
                        r_num_out <= i_num_out;
                        r_relu    <= i_relu_en;
                        r_in_idx  <= '0;
                        r_out_idx <= '0;
                        r_wptr    <= '0;
                        // empty job: nothing to read or write
                        r_state   <= (i_num_cnt == '0 || i_num_out == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_wptr <= r_wptr + A_ONE;
                    if (w_in_last) begin
                        r_in_idx  <= '0;
                        r_out_idx <= r_out_idx + C_ONE;
                        if (w_out_last)
                            r_state <= ST_FLUSH;
                    end else begin
                        r_in_idx <= r_in_idx + C_ONE;
                    end
                end
                ST_FLUSH: begin
                    if (r_wr_last)
                        r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // delay read tags one cycle to meet BRAM data, then form the write strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld       <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_last_node <= 1'b0;
            r_out_d1    <= '0;
            r_we_b2     <= 1'b0;
            r_wr_last   <= 1'b0;
            r_addr_b2   <= '0;
        end else begin
            r_vld       <= w_issue;
            r_first     <= w_issue && (r_in_idx == '0);
            r_last      <= w_issue && w_in_last;
            r_last_node <= w_issue && w_in_last && w_out_last;
            r_out_d1    <= r_out_idx[AWIDTH-1:0];
            r_we_b2     <= r_vld && r_last;
            r_wr_last   <= r_vld && r_last_node;
            if (r_vld && r_last)
                r_addr_b2 <= r_out_d1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_LANE; k++) begin : g_lane
            fc_mac_lane #(
                .IN_W  (IN_DATA_WIDTH),
                .ACC_W (ACC_W)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .i_vld   (r_vld),
                .i_first (r_first),
                .i_relu  (r_relu),
                .i_a     (bus.q_b0[(NUM_LANE-k)*IN_DATA_WIDTH-1 -: IN_DATA_WIDTH]),
                .i_b     (bus.q_b1[(NUM_LANE-k)*IN_DATA_WIDTH-1 -: IN_DATA_WIDTH]),
                .o_res   (w_d_b2[(NUM_LANE-k)*ACC_W-1 -: ACC_W])
            );
        end
    endgenerate

    assign o_idle = (r_state == ST_IDLE);
    assign o_run  = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign o_done = (r_state == ST_DONE);

    assign bus.addr_b0 = w_issue ? r_in_idx[AWIDTH-1:0] : '0;
    assign bus.ce_b0   = w_issue;
    assign bus.we_b0   = 1'b0;
    assign bus.d_b0    = '0;

    assign bus.addr_b1 = w_issue ? r_wptr : '0;
    assign bus.ce_b1   = w_issue;
    assign bus.we_b1   = 1'b0;
    assign bus.d_b1    = '0;

    assign bus.addr_b2 = r_addr_b2;
    assign bus.ce_b2   = r_we_b2;
    assign bus.we_b2   = r_we_b2;
    assign bus.d_b2    = w_d_b2;

endmodule

// File: tb/tb_fc_data_mover_ncore.sv
// Bench for fc_data_mover_ncore: behavioural 1-cycle BRAMs, a write
// scoreboard filled when each job is launched, and read-address/timing checks.
module tb_fc_data_mover_ncore;
    localparam int CNT_BIT = 31;
    localparam int DWIDTH  = 32;
    localparam int AWIDTH  = 12;
    localparam int IDW     = 8;
    localparam int OW      = 128;

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [OW-1:0]     data;
    } wr_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               i_run = 1'b0;
    logic               i_relu_en = 1'b0;
    logic [CNT_BIT-1:0] i_num_cnt = '0;
    logic [CNT_BIT-1:0] i_num_out = '0;
    logic               o_idle, o_run, o_done;

    logic [DWIDTH-1:0]  mem0 [0:4095];
    logic [DWIDTH-1:0]  mem1 [0:4095];

    wr_t sb_q[$];
    int  wt_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc_g   = 0;
    int  rd_cnt  = 0;
    int  cur_n   = 0;

    fc_data_mover_ncore_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .OWIDTH(OW)) bus ();

    fc_data_mover_ncore #(
        .CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .IN_DATA_WIDTH(IDW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run),
        .i_num_cnt(i_num_cnt), .i_num_out(i_num_out), .i_relu_en(i_relu_en),
        .o_idle(o_idle), .o_run(o_run), .o_done(o_done), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_g <= cyc_g + 1;

    // 1-cycle read latency BRAM models
    always @(posedge clk) begin
        if (bus.ce_b0) bus.q_b0 <= mem0[bus.addr_b0];
        if (bus.ce_b1) bus.q_b1 <= mem1[bus.addr_b1];
    end

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [OW-1:0] model(input int n, input int j, input bit relu);
        logic [OW-1:0]     r = '0;
        logic [DWIDTH-1:0] a, b;
        logic [AWIDTH-1:0] wa;
        int                acc;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int i = 0; i < n; i++) begin
                a   = mem0[i];
                wa  = AWIDTH'(j * n + i);
                b   = mem1[wa];
                acc = acc + int'($signed(a[(4-k)*8-1 -: 8])) * int'($signed(b[(4-k)*8-1 -: 8]));
            end
            if (relu && acc < 0) acc = 0;
            r[(4-k)*32-1 -: 32] = acc;
        end
        return r;
    endfunction

    task automatic push_model(input int n, input int m, input bit relu);
        for (int j = 0; j < m; j++) sb_q.push_back('{AWIDTH'(j), model(n, j, relu)});
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_flags"}, {o_idle, o_run, o_done}, 3'b100);
        chk({tag, "_ce"}, {bus.ce_b0, bus.ce_b1, bus.ce_b2, bus.we_b2}, 4'b0000);
        chk({tag, "_addr"}, {bus.addr_b0, bus.addr_b1, bus.addr_b2}, '0);
        chk({tag, "_d"}, bus.d_b2, '0);
    endtask

    // read-address, write-content and write-timing monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ce_b0 || bus.ce_b1) begin
                chk("ce_pair", bus.ce_b1, bus.ce_b0);
                if (cur_n == 0) begin
                    chk("rd_when_empty", {bus.ce_b0, bus.ce_b1}, 2'b00);
                end else begin
                    chk("rd_a0", bus.addr_b0, AWIDTH'(rd_cnt % cur_n));
                    chk("rd_a1", bus.addr_b1, AWIDTH'(rd_cnt));
                    if (rd_cnt % cur_n == cur_n - 1) wt_q.push_back(cyc_g + 2);
                end
                rd_cnt++;
            end
            if (bus.ce_b2 || bus.we_b2) begin
                if (sb_q.size() == 0) begin
                    chk("unexp_wr", {bus.ce_b2, bus.we_b2}, 2'b00);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    chk("wr_cewe", {bus.ce_b2, bus.we_b2}, 2'b11);
                    chk("wr_addr", bus.addr_b2, e.addr);
                    chk("wr_data", bus.d_b2, e.data);
                    if (wt_q.size() > 0) chk("wr_time", cyc_g, wt_q.pop_front());
                    else                 chk("wr_time_q", wt_q.size(), 1);
                end
            end
        end
    end

    task automatic run_case(input int n, input int m, input bit relu, input bit dbl);
        int cyc;
        int exp_cyc;
        cur_n   = n;
        rd_cnt  = 0;
        exp_cyc = (n == 0 || m == 0) ? 0 : n * m + 2;
        @(negedge clk);
        i_num_cnt = CNT_BIT'(n);
        i_num_out = CNT_BIT'(m);
        i_relu_en = relu;
        i_run     = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        chk("run_flag", o_run, exp_cyc != 0);
        cyc = 0;
        while (!o_done && cyc < 5000) begin
            i_run = dbl && (cyc == 1);
            if (dbl) begin
                i_num_cnt = CNT_BIT'(3);
                i_num_out = CNT_BIT'(9);
                i_relu_en = !relu;
            end
            @(negedge clk);
            cyc++;
        end
        i_run = 1'b0;
        chk("done_cyc", cyc, exp_cyc);
        if (exp_cyc == 0) chk("zero_ce", {bus.ce_b0, bus.ce_b1, bus.ce_b2, bus.we_b2}, 4'b0000);
        @(negedge clk);
        chk("done_pulse", {o_idle, o_done}, 2'b10);
        chk("rd_count", rd_cnt, n * m);
        chk("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_check("rst");
        reset_n = 1'b1;
        @(negedge clk);
        rst_check("post_rst");

        // single word, single node
        mem0[0] = 32'h01020304;
        mem1[0] = 32'h05060708;
        sb_q.push_back('{12'd0, {32'd5, 32'd12, 32'd21, 32'd32}});
        run_case(1, 1, 1'b0, 1'b0);

        // all-ones, N=4 M=3
        for (int i = 0; i < 12; i++) begin
            mem0[i] = 32'h01010101;
            mem1[i] = 32'h01010101;
        end
        for (int j = 0; j < 3; j++) sb_q.push_back('{AWIDTH'(j), {4{32'd4}}});
        run_case(4, 3, 1'b0, 1'b0);

        // negative result, raw then ReLU
        mem0[0] = 32'hFFFFFFFF; mem0[1] = 32'hFFFFFFFF;
        mem1[0] = 32'h02020202; mem1[1] = 32'h02020202;
        sb_q.push_back('{12'd0, {4{32'hFFFFFFFC}}});
        run_case(2, 1, 1'b0, 1'b0);
        sb_q.push_back('{12'd0, {OW{1'b0}}});
        run_case(2, 1, 1'b1, 1'b0);

        // empty jobs
        run_case(0, 5, 1'b0, 1'b0);
        run_case(3, 0, 1'b0, 1'b0);

        // random data, both ReLU settings
        for (int i = 0; i < 64; i++) begin
            mem0[i] = $urandom;
            mem1[i] = $urandom;
        end
        push_model(5, 3, 1'b1);
        run_case(5, 3, 1'b1, 1'b0);
        push_model(5, 3, 1'b0);
        run_case(5, 3, 1'b0, 1'b0);

        // i_run re-pulsed (with changed config) during RUN is ignored
        push_model(4, 3, 1'b0);
        run_case(4, 3, 1'b0, 1'b1);

        // reset during read 5 of N=8 M=2, then rerun
        cur_n  = 8;
        rd_cnt = 0;
        @(negedge clk);
        i_num_cnt = CNT_BIT'(8);
        i_num_out = CNT_BIT'(2);
        i_relu_en = 1'b0;
        i_run     = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        repeat (4) @(negedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        rst_check("abort");
        sb_q.delete();
        wt_q.delete();
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_idle", {o_idle, o_run, o_done}, 3'b100);
        push_model(8, 2, 1'b0);
        run_case(8, 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/fc_data_mover_ncore.md
FC_DATA_MOVER_NCORE -- requirements
Module: fc_data_mover_ncore

Interface
REQ-001 Parameter CNT_BIT, 31, width of count inputs and internal counters.
REQ-002 Parameter DWIDTH, 32, BRAM0/BRAM1 word width.
REQ-003 Parameter AWIDTH, 12, address width of all BRAM ports.
REQ-004 Parameter IN_DATA_WIDTH, 8, signed lane operand width; NUM_LANE = DWIDTH/IN_DATA_WIDTH; ACC_W = 4*IN_DATA_WIDTH.
REQ-005 clk  input  1  clock, all flops rising-edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_run  input  1  start pulse, sampled only in IDLE.
REQ-008 i_num_cnt  input  CNT_BIT  input words per output node (N).
REQ-009 i_num_out  input  CNT_BIT  output nodes to compute (M).
REQ-010 i_relu_en  input  1  ReLU on written results, captured with i_run.
REQ-011 o_idle / o_run / o_done  output  1 each  state flags; o_done one-cycle pulse.
REQ-012 addr_b0, ce_b0  output  AWIDTH, 1  node BRAM read port; we_b0 tied 0, d_b0 tied 0; q_b0 input DWIDTH.
REQ-013 addr_b1, ce_b1  output  AWIDTH, 1  weight BRAM read port; we_b1 tied 0, d_b1 tied 0; q_b1 input DWIDTH.
REQ-014 addr_b2, ce_b2, we_b2, d_b2  output  AWIDTH, 1, 1, NUM_LANE*ACC_W  result BRAM write port.

Function
REQ-015 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on i_run; RUN->FLUSH after last read issued; FLUSH->DONE after last write; DONE->IDLE unconditionally.
REQ-016 i_run with N==0 or M==0 goes IDLE->DONE directly; no ce/we asserted.
REQ-017 N, M, relu_en captured on i_run in IDLE; i_run in any other state ignored.
REQ-018 RUN issues one read per cycle, no bubbles: addr_b0 = in_idx, addr_b1 = running weight pointer (out_idx*N + in_idx), ce_b0 = ce_b1 = 1.
REQ-019 in_idx wraps 0..N-1; on wrap out_idx increments; weight pointer increments every read, truncated to AWIDTH.
REQ-020 BRAM read latency 1 cycle; valid and first/last tags delayed 1 cycle to align with q_b0/q_b1.
REQ-021 Lane k uses bits [(NUM_LANE-k)*IN_DATA_WIDTH-1 -: IN_DATA_WIDTH] of q_b0 and q_b1 (lane 0 = MSB byte), signed multiply.
REQ-022 Accumulator per lane, ACC_W signed, loads product on first element of a node, adds otherwise; two's-complement wrap, no saturation.
REQ-023 Write one cycle after last accumulate: ce_b2 = we_b2 = 1 for one cycle, addr_b2 = out_idx of that node, d_b2 = lane results, lane 0 in MSBs.
REQ-024 relu_en=1: negative lane result written as 0; relu_en=0: raw value.
REQ-025 Read-to-write latency: write of node j occurs 2 cycles after its last read issue; total run = N*M + 2 cycles from RUN entry to DONE.
REQ-026 o_idle = IDLE, o_run = RUN or FLUSH, o_done = DONE.

Reset
REQ-027 reset_n low at any time forces IDLE, clears counters, accumulators, tags, captured config.
REQ-028 During and after reset: o_idle=1, o_run=0, o_done=0, all ce/we=0, all addresses 0, d_b2=0.
REQ-029 Reset mid-run aborts; no further write; next i_run restarts from index 0.

Structure
REQ-030 Shared package fc_pkg holds state encodings and ACC_W derivation function.
REQ-031 One sub-module fc_mac_lane (signed multiply-accumulate, first-load, ReLU), instantiated NUM_LANE times via generate.

Verification
REQ-032 N=1, M=1, q_b0=0x01020304, q_b1=0x05060708 -> one write addr 0, d_b2 lanes {5,12,21,32}, o_done 3 cycles after RUN entry.
REQ-033 N=4, M=3, all bytes 1 in both BRAMs -> writes at addr 0,1,2 each lane=4, weight addresses 0..11, back-to-back reads.
REQ-034 Node byte 0xFF (-1), weight 0x02, N=2, relu_en=0 -> lane=-4 (0xFFFFFFFC); relu_en=1 -> 0.
REQ-035 N=0, M=5 -> IDLE, DONE, IDLE; no ce/we asserted.
REQ-036 reset_n low at read 5 of N=8, M=2 -> all outputs reset values next cycle, no write; rerun yields correct results.
REQ-037 i_run pulsed during RUN -> ignored; results and timing identical to single-start run.
